// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating WAIT-cycle counter; expired flags the last allowed WAIT cycle.
module arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_wdog
      assign expired = 1'b0;
    end else begin : g_wdog
      assign expired = (count == TW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU (read) and LSU
// (read/write), one outstanding transaction, with a response watchdog.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_reqValid,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_respValid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_reqValid,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wbmask,
  output logic              lsu_respValid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_reqValid,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wbmask,
  input  logic              mem_respValid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              err_timeout,
  output logic              err_stray,
  output arb_state_t        dbg_state
);

  // Handshake: a requester holds reqValid high until its respValid strobe
  // (one cycle) and drops it in the following cycle. Requests are only
  // sampled in IDLE; toward RAM, mem_reqValid is a one-cycle pulse and the
  // RAM answers with a one-cycle mem_respValid while the arbiter is in WAIT.

  arb_state_t        state, state_nxt;
  logic              grant, grant_lsu;
  logic              resp, timeout_hit;
  logic [DATA_W-1:0] resp_data;
  logic              expired;

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clock),
    .rst_n  (reset),
    .clear  (state == ISSUE),
    .enable (state == WAIT),
    .expired(expired)
  );

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_lsu   = 1'b0;
    resp        = 1'b0;
    resp_data   = '0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_reqValid || lsu_reqValid) begin
          grant     = 1'b1;
          // On a tie the requester that did not own the last grant wins.
          grant_lsu = lsu_reqValid && (!ifu_reqValid || (owner == OWN_IFU));
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (mem_respValid) begin
          resp      = 1'b1;
          resp_data = mem_rdata;
          state_nxt = IDLE;
        end else if (expired) begin
          resp        = 1'b1;
          resp_data   = ERR_DATA;
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_LSU;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wbmask  <= 4'h0;
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= grant_lsu ? OWN_LSU : OWN_IFU;
        if (grant_lsu) begin
          mem_wen    <= lsu_wen;
          mem_addr   <= lsu_addr;
          mem_wdata  <= lsu_wdata;
          mem_wbmask <= lsu_wbmask;
        end else begin
          mem_wen    <= 1'b0;
          mem_addr   <= ifu_addr;
          mem_wdata  <= '0;
          mem_wbmask <= 4'h0;
        end
      end
      if (timeout_hit) err_timeout <= 1'b1;
      if (mem_respValid && (state != WAIT)) err_stray <= 1'b1;
    end
  end

  assign mem_reqValid  = (state == ISSUE);
  assign ifu_respValid = resp && (owner == OWN_IFU);
  assign lsu_respValid = resp && (owner == OWN_LSU);
  assign ifu_rdata     = ifu_respValid ? resp_data : '0;
  assign lsu_rdata     = lsu_respValid ? resp_data : '0;
  assign dbg_state     = state;

endmodule
